// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arbitrated N-channel mux.
//   ARB_RR / ARB_FIXED : encoding of the arbitration mode input
//   stage_e            : state of the single output register stage
package arb_mux_pkg;

  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_e;

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational one-hot arbiter.
//   req_i  : request vector, one bit per channel
//   ptr_i  : round-robin search start index
//   mode_i : ARB_RR searches from ptr_i with wrap, ARB_FIXED searches from 0
//   gnt_o  : one-hot grant (all zero when no request)
//   idx_o  : binary index of the granted channel
//   any_o  : at least one request present
module rr_arbiter_n
  import arb_mux_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  input  logic              mode_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [SEL_W-1:0]  idx_o,
  output logic              any_o
);

  always_comb begin : search
    int   start;
    int   idx;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    idx   = 0;
    start = (mode_i == ARB_FIXED) ? 0 : int'(ptr_i);
    // Walk every channel once starting at 'start'; first requester wins.
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (start + i) % NUM_CH;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        idx_o      = SEL_W'(idx);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel arbitrated mux with a single registered output stage.
// Optional feature macro: ARB_MUX_N_LOCK_EN (packet lock until i_last beat).
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_valid/o_ready/i_data/i_last : per-channel input beats (data flattened)
//   i_prio_mode             : 0 round-robin, 1 fixed priority (lowest index)
//   o_valid/i_ready         : output handshake
//   o_data/o_last/o_sel     : registered beat, its last flag and source channel
module arb_mux_n
  import arb_mux_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int NUM_CH    = 8,
  parameter int SEL_W     = $clog2(NUM_CH)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_CH-1:0]           i_valid,
  output logic [NUM_CH-1:0]           o_ready,
  input  logic [NUM_CH*BIT_WIDTH-1:0] i_data,
  input  logic [NUM_CH-1:0]           i_last,
  input  logic                        i_prio_mode,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [BIT_WIDTH-1:0]        o_data,
  output logic                        o_last,
  output logic [SEL_W-1:0]            o_sel
);

  stage_e                state_q, state_d;
  logic [BIT_WIDTH-1:0]  data_q, data_d;
  logic                  last_q, last_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [SEL_W-1:0]      ptr_q, ptr_d;

  logic [NUM_CH-1:0]     req;
  logic [NUM_CH-1:0]     gnt;
  logic [SEL_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic                  mode_eff;
  logic                  can_accept;
  logic                  accept;
  logic [BIT_WIDTH-1:0]  sel_data;
  logic                  sel_last;

`ifdef ARB_MUX_N_LOCK_EN
  logic                  lock_q, lock_d;
  logic [SEL_W-1:0]      lock_ch_q, lock_ch_d;
  logic                  lock_mode_q, lock_mode_d;
  localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

  // While locked only the owning channel may request, and the mode seen at
  // lock time stays in force so a mode change waits for the packet end.
  assign req      = lock_q ? (i_valid & (ONE_HOT0 << lock_ch_q)) : i_valid;
  assign mode_eff = lock_q ? lock_mode_q : i_prio_mode;

  always_comb begin
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    lock_mode_d = lock_mode_q;
    if (accept) begin
      lock_d      = !sel_last;
      lock_ch_d   = gnt_idx;
      lock_mode_d = mode_eff;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
      lock_mode_q <= ARB_RR;
    end else begin
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      lock_mode_q <= lock_mode_d;
    end
  end
`else
  assign req      = i_valid;
  assign mode_eff = i_prio_mode;
`endif

  rr_arbiter_n #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .mode_i (mode_eff),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  // Drain and refill in the same cycle when the consumer takes the held beat.
  assign can_accept = (state_q == ST_EMPTY) || i_ready;
  assign accept     = can_accept && gnt_any;
  assign o_ready    = (can_accept && i_rst_n) ? gnt : '0;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt_idx == SEL_W'(k)) begin
        sel_data = i_data[k*BIT_WIDTH +: BIT_WIDTH];
        sel_last = i_last[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (accept) begin
      state_d = ST_FULL;
      data_d  = sel_data;
      last_d  = sel_last;
      sel_d   = gnt_idx;
      if (mode_eff == ARB_RR) begin
        ptr_d = (gnt_idx == SEL_W'(NUM_CH-1)) ? '0 : gnt_idx + SEL_W'(1);
      end
    end else if ((state_q == ST_FULL) && i_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      last_q  <= 1'b0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_valid = (state_q == ST_FULL);
  assign o_data  = data_q;
  assign o_last  = last_q;
  assign o_sel   = sel_q;

endmodule

// File: doc/arb_mux_n.md
ARB_MUX_N -- requirements
Module: arb_mux_n

Interface
REQ-001 Parameter BIT_WIDTH, default 16, data width per channel in bits (1..64).
REQ-002 Parameter NUM_CH, default 8, number of input channels (2..16).
REQ-003 Parameter SEL_W, default $clog2(NUM_CH), width of channel index.
REQ-004 i_clk  in  1  single clock, all state on rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_valid  in  NUM_CH  per-channel beat valid.
REQ-007 o_ready  out  NUM_CH  per-channel beat accepted this cycle.
REQ-008 i_data  in  NUM_CH*BIT_WIDTH  flattened channel data, channel k at bits [k*BIT_WIDTH +: BIT_WIDTH].
REQ-009 i_last  in  NUM_CH  per-channel last-beat-of-packet flag.
REQ-010 i_prio_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-011 o_valid  out  1  output register holds a beat.
REQ-012 i_ready  in  1  downstream accepts o_data.
REQ-013 o_data  out  BIT_WIDTH  registered selected data.
REQ-014 o_last  out  1  registered i_last of selected beat.
REQ-015 o_sel  out  SEL_W  channel index of beat in output register.

Function
REQ-016 Output stage is one register, states EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-017 Stage can accept when EMPTY, or FULL with i_ready=1 (same-cycle drain and refill).
REQ-018 When stage can accept and any i_valid set, exactly one channel g is granted: o_ready[g]=1, all other o_ready bits 0; o_ready is all-zero otherwise.
REQ-019 o_ready depends combinationally on i_valid, i_ready, i_prio_mode and state, never on i_data.
REQ-020 Accepted beat appears on o_data/o_last/o_sel with o_valid=1 in the next cycle (latency 1).
REQ-021 FULL with i_ready=1 and no grant: next state EMPTY; FULL with i_ready=0: register held unchanged.
REQ-022 Round-robin: search starts at pointer p and wraps modulo NUM_CH; pointer updates to (g+1) mod NUM_CH only on acceptance.
REQ-023 Fixed priority: lowest-index valid channel wins; pointer not updated.
REQ-024 i_prio_mode change takes effect on the next arbitration decision; no beat lost or duplicated.
REQ-025 Channel with i_valid=0 is never granted; all channels idle leaves pointer unchanged.
REQ-026 Pointer wrap: grant to NUM_CH-1 sets pointer to 0.

Reset
REQ-027 Asserting i_rst_n low immediately forces o_valid=0, o_data=0, o_last=0, o_sel=0, pointer=0, lock cleared; o_ready=0 while in reset.
REQ-028 Reset mid-packet or with FULL register discards the held beat; first cycle after release behaves as fresh EMPTY state.

Configuration
REQ-029 Macro ARB_MUX_N_LOCK_EN defined: after accepting a beat from g with i_last=0, grant is locked to g until a beat from g with i_last=1 is accepted; other channels are not granted even if g drops i_valid; mode change is deferred until unlock.
REQ-030 Macro undefined: i_last only passes through to o_last; arbitration is per beat; no lock state exists.

Structure
REQ-031 Shared package arb_mux_pkg holds the mode encoding constants (ARB_RR=0, ARB_FIXED=1) and the state encoding of the output stage.
REQ-032 One sub-module, rr_arbiter_n (parametrised by NUM_CH), computes the one-hot grant from request vector, pointer and mode; data selection reuses the team mux style inside arb_mux_n.

Verification
REQ-033 NUM_CH=4, RR, i_valid=4'b1111 continuously, i_ready=1 -> o_sel sequence 0,1,2,3,0, one beat per cycle, o_valid stays 1.
REQ-034 Fixed mode, i_valid=4'b1010 held -> o_sel always 1; channel 3 never granted until channel 1 drops valid.
REQ-035 Register FULL with data 16'hA5A5, i_ready=0 for 3 cycles -> o_data holds 16'hA5A5, o_ready=4'b0000; i_ready=1 with channel 2 valid -> same-cycle refill, next o_sel=2.
REQ-036 Pointer=3, only channel 3 then channel 0 valid on successive cycles -> grants 3 then 0, pointer wraps to 1.
REQ-037 LOCK_EN, ch1 sends 3 beats last=0,0,1 while ch0/ch2 valid -> all three beats from ch1 consecutively, then ch2 granted.
REQ-038 i_rst_n pulsed low while FULL and locked -> o_valid=0 asynchronously, pointer=0, next grant follows fresh priority from channel 0.
